// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - start/done handshake bundle between the control unit and shift_sequencer
interface shift_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  modport master (
    output start, op, A, B,
    input  busy, done, result, err
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, err
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift/rotate engine moving at most STEP bits per clock
// Optional rotate datapath (ROL/ROR) enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
  parameter int STEP = 1
) (
  input logic              clk,
  input logic              reset_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [5:0] STEP_W  = 6'(STEP);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] data;
  logic [5:0]  count;
  logic [2:0]  op_q;
  logic [31:0] result_q;
  logic        err_q;

  logic        accept;
  logic        is_rot;
  logic        op_legal;
  logic        load_done;
  logic [5:0]  k_load;
  logic [5:0]  s;
  logic [5:0]  count_nxt;
  logic [31:0] data_shift;

  // Decode of the request: legality and the clamped/wrapped shift amount.
  always_comb begin
    accept = bus.start && ((state == S_IDLE) || (state == S_DONE));
    is_rot = (bus.op == OP_ROL) || (bus.op == OP_ROR);
`ifdef SHIFT_SEQ_ROTATE_EN
    op_legal = (bus.op <= OP_ROR);
`else
    op_legal = (bus.op <= OP_SHRA);
`endif
    if (is_rot) begin
      k_load = {1'b0, bus.B[4:0]};
    end else if (|bus.B[31:5]) begin
      k_load = 6'd32;
    end else begin
      k_load = {1'b0, bus.B[4:0]};
    end
    load_done = !op_legal || (k_load == 6'd0);
  end

  // One iteration of the shifter: s = min(STEP, count).
  always_comb begin
    s         = (count < STEP_W) ? count : STEP_W;
    count_nxt = count - s;
    case (op_q)
      OP_SHL:  data_shift = data << s;
      OP_SHR:  data_shift = data >> s;
      OP_SHRA: data_shift = 32'($signed(data) >>> s);
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROL:  data_shift = (data << s) | (data >> (6'd32 - s));
      OP_ROR:  data_shift = (data >> s) | (data << (6'd32 - s));
`endif
      default: data_shift = data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = load_done ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (count_nxt == 6'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (accept) begin
          state_nxt = load_done ? S_DONE : S_SHIFT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand, counter and result registers; result only moves on the edge into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= 32'd0;
      count    <= 6'd0;
      op_q     <= 3'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else if (accept) begin
      data  <= bus.A;
      op_q  <= bus.op;
      count <= k_load;
      err_q <= !op_legal;
      if (load_done) begin
        result_q <= bus.A;
      end
    end else if (state == S_SHIFT) begin
      data  <= data_shift;
      count <= count_nxt;
      if (count_nxt == 6'd0) begin
        result_q <= data_shift;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed bench for shift_sequencer at STEP=1 and STEP=4
module tb_shift_sequencer;

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_sequencer_if if1 ();
  shift_sequencer_if if4 ();

  shift_sequencer #(.STEP(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  shift_sequencer #(.STEP(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));

  task automatic drive(input int sel, input logic st, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel == 4) begin
      if4.start = st; if4.op = o; if4.A = a; if4.B = b;
    end else begin
      if1.start = st; if1.op = o; if1.A = a; if1.B = b;
    end
  endtask

  // Issues one operation and measures: cycle of done, busy cycles, first busy cycle.
  task automatic run_op(input int sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int dc, output int bc, output int bf,
                        output logic [31:0] r, output logic e, output bit ov);
    logic bsy, dn;
    dc = 0; bc = 0; bf = 0; ov = 0; r = 'x; e = 'x;
    @(negedge clk);
    drive(sel, 1'b1, o, a, b);
    @(negedge clk);
    drive(sel, 1'b0, o, a, b);
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      bsy = (sel == 4) ? if4.busy : if1.busy;
      dn  = (sel == 4) ? if4.done : if1.done;
      if (bsy && dn) ov = 1;
      if (bsy) begin
        bc++;
        if (bf == 0) bf = c;
      end
      if (dn) begin
        dc = c;
        r  = (sel == 4) ? if4.result : if1.result;
        e  = (sel == 4) ? if4.err : if1.err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({if1.busy, if1.done, if1.err, if1.result} !== 35'd0) begin
      errors++; $display("FAIL reset_step1 got %h exp 0", {if1.busy, if1.done, if1.err, if1.result});
    end
    checks++;
    if ({if4.busy, if4.done, if4.err, if4.result} !== 35'd0) begin
      errors++; $display("FAIL reset_step4 got %h exp 0", {if4.busy, if4.done, if4.err, if4.result});
    end
  endtask

  task automatic test_shl;
    int dc, bc, bf; logic [31:0] r; logic e; bit ov;
    run_op(1, OP_SHL, 32'h1, 32'd4, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 5) begin errors++; $display("FAIL shl_done_cycle got %0d exp 5", dc); end
    checks++; if (bc !== 4 || bf !== 1) begin errors++; $display("FAIL shl_busy got %0d/%0d exp 4/1", bc, bf); end
    checks++; if (r !== 32'h10) begin errors++; $display("FAIL shl_result got %h exp 00000010", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL shl_err got %b exp 0", e); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL shl_overlap got %b exp 0", ov); end
    run_op(4, OP_SHL, 32'h1, 32'd5, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 3 || bc !== 2) begin errors++; $display("FAIL shl4_timing got %0d/%0d exp 3/2", dc, bc); end
    checks++; if (r !== 32'h20) begin errors++; $display("FAIL shl4_result got %h exp 00000020", r); end
  endtask

  task automatic test_clamp;
    int dc, bc, bf; logic [31:0] r; logic e; bit ov;
    run_op(1, OP_SHRA, 32'h8000_0000, 32'd40, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 33 || bc !== 32) begin errors++; $display("FAIL shra_clamp_timing got %0d/%0d exp 33/32", dc, bc); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL shra_clamp_result got %h exp ffffffff", r); end
    run_op(1, OP_SHR, 32'h8000_0000, 32'd40, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 33) begin errors++; $display("FAIL shr_clamp_cycle got %0d exp 33", dc); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL shr_clamp_result got %h exp 00000000", r); end
    run_op(1, OP_SHL, 32'hFFFF_FFFF, 32'h0001_0000, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 33 || r !== 32'h0) begin errors++; $display("FAIL shl_upper_clamp got %0d/%h exp 33/00000000", dc, r); end
    run_op(4, OP_SHRA, 32'h8000_0000, 32'd40, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 9 || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL shra4_clamp got %0d/%h exp 9/ffffffff", dc, r); end
  endtask

  task automatic test_rotate;
    int dc, bc, bf; logic [31:0] r; logic e; bit ov;
    run_op(4, OP_ROR, 32'h0000_00F1, 32'd36, dc, bc, bf, r, e, ov);
`ifdef SHIFT_SEQ_ROTATE_EN
    checks++; if (dc !== 2 || r !== 32'h1000_000F || e !== 1'b0) begin
      errors++; $display("FAIL ror4 got %0d/%h/%b exp 2/1000000f/0", dc, r, e); end
`else
    checks++; if (dc !== 1 || r !== 32'h0000_00F1 || e !== 1'b1) begin
      errors++; $display("FAIL ror4_disabled got %0d/%h/%b exp 1/000000f1/1", dc, r, e); end
`endif
    run_op(1, OP_ROL, 32'h8000_0001, 32'd1, dc, bc, bf, r, e, ov);
`ifdef SHIFT_SEQ_ROTATE_EN
    checks++; if (dc !== 2 || r !== 32'h0000_0003 || e !== 1'b0) begin
      errors++; $display("FAIL rol1 got %0d/%h/%b exp 2/00000003/0", dc, r, e); end
`else
    checks++; if (dc !== 1 || r !== 32'h8000_0001 || e !== 1'b1) begin
      errors++; $display("FAIL rol1_disabled got %0d/%h/%b exp 1/80000001/1", dc, r, e); end
`endif
    run_op(1, OP_ROR, 32'hDEAD_BEEF, 32'd32, dc, bc, bf, r, e, ov);
`ifdef SHIFT_SEQ_ROTATE_EN
    checks++; if (dc !== 1 || r !== 32'hDEAD_BEEF || e !== 1'b0) begin
      errors++; $display("FAIL ror_mod32 got %0d/%h/%b exp 1/deadbeef/0", dc, r, e); end
`else
    checks++; if (dc !== 1 || r !== 32'hDEAD_BEEF || e !== 1'b1) begin
      errors++; $display("FAIL ror_mod32_disabled got %0d/%h/%b exp 1/deadbeef/1", dc, r, e); end
`endif
  endtask

  task automatic test_zero_illegal;
    int dc, bc, bf; logic [31:0] r; logic e; bit ov;
    run_op(1, OP_SHR, 32'h0000_1234, 32'd0, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 1 || bc !== 0) begin errors++; $display("FAIL zero_timing got %0d/%0d exp 1/0", dc, bc); end
    checks++; if (r !== 32'h1234 || e !== 1'b0) begin errors++; $display("FAIL zero_result got %h/%b exp 00001234/0", r, e); end
    run_op(1, 3'd7, 32'h0000_1234, 32'd5, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 1 || bc !== 0) begin errors++; $display("FAIL illegal_timing got %0d/%0d exp 1/0", dc, bc); end
    checks++; if (r !== 32'h1234 || e !== 1'b1) begin errors++; $display("FAIL illegal_result got %h/%b exp 00001234/1", r, e); end
    repeat (3) @(negedge clk);
    checks++; if (if1.err !== 1'b1) begin errors++; $display("FAIL illegal_err_held got %b exp 1", if1.err); end
    run_op(4, 3'd5, 32'hCAFE_0000, 32'd3, dc, bc, bf, r, e, ov);
    checks++; if (dc !== 1 || r !== 32'hCAFE_0000 || e !== 1'b1) begin
      errors++; $display("FAIL illegal5 got %0d/%h/%b exp 1/cafe0000/1", dc, r, e); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); drive(1, 1'b1, OP_SHL, 32'h1, 32'd3);
    @(negedge clk); drive(1, 1'b0, OP_SHL, 32'h1, 32'd3);
    checks++; if (if1.busy !== 1'b1 || if1.err !== 1'b0) begin
      errors++; $display("FAIL b2b_first_busy got %b/%b exp 1/0", if1.busy, if1.err); end
    @(negedge clk); drive(1, 1'b1, OP_SHR, 32'hFF, 32'd4);
    @(negedge clk); drive(1, 1'b0, OP_SHR, 32'hFF, 32'd4);
    checks++; if (if1.busy !== 1'b1) begin errors++; $display("FAIL b2b_ignored_busy got %b exp 1", if1.busy); end
    @(negedge clk);
    checks++; if (if1.done !== 1'b1 || if1.result !== 32'h8) begin
      errors++; $display("FAIL b2b_first_done got %b/%h exp 1/00000008", if1.done, if1.result); end
    drive(1, 1'b1, OP_SHL, 32'h3, 32'd2);
    @(negedge clk); drive(1, 1'b0, OP_SHL, 32'h3, 32'd2);
    checks++; if ({if1.busy, if1.done} !== 2'b10 || if1.result !== 32'h8) begin
      errors++; $display("FAIL b2b_second_start got %b/%h exp 10/00000008", {if1.busy, if1.done}, if1.result); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (if1.done !== 1'b1 || if1.result !== 32'hC) begin
      errors++; $display("FAIL b2b_second_done got %b/%h exp 1/0000000c", if1.done, if1.result); end
  endtask

  task automatic test_async_reset;
    bit seen;
    @(negedge clk); drive(1, 1'b1, OP_SHL, 32'h1, 32'd10);
    @(negedge clk); drive(1, 1'b0, OP_SHL, 32'h1, 32'd10);
    @(negedge clk);
    checks++; if (if1.busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %b exp 1", if1.busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({if1.busy, if1.done, if1.err, if1.result} !== 35'd0) begin
      errors++; $display("FAIL areset_clear got %h exp 0", {if1.busy, if1.done, if1.err, if1.result}); end
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (if1.done || if1.busy) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL areset_no_done got %b exp 0", seen); end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(4, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    test_shl;
    test_clamp;
    test_rotate;
    test_zero_illegal;
    test_back_to_back;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift/rotate engine that sequences a 32-bit operand through logical, arithmetic and rotate shifts, moving at most STEP bit positions per clock. It sits beside the single-cycle ALU shifter and serves area-constrained or multi-cycle instruction paths. The control unit drives it through a start/done handshake. It owns the operand register, the remaining-count counter and the operation state machine.

## Interface
- STEP, 1: maximum bit positions shifted per cycle. Legal values are 1, 2, 4 and 8.
- clk  in  1: rising-edge clock.
- reset_n  in  1: asynchronous, active-low reset.
- start  in  1: request pulse. Accepted only in IDLE or DONE.
- op  in  3: operation code.
  - 000 SHL.
  - 001 SHR (logical).
  - 010 SHRA (arithmetic).
  - 011 ROL.
  - 100 ROR.
  - 101–111 illegal.
- A  in  32: data to shift. Sampled on the accepting edge.
- B  in  32: shift amount. Sampled on the accepting edge.
- busy  out  1: high while in SHIFT.
- done  out  1: one-cycle pulse, high while in DONE.
- result  out  32: final value. Held until the next completion.
- err  out  1: illegal or disabled op. Valid with done and held until the next accepted start.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: iterating.
  - DONE: single cycle, then IDLE unless start is high.
- Accept (start=1 in IDLE or DONE):
  - Load data←A and opcode.
  - Load count←k:
    - SHL, SHR, SHRA: k = min(B, 32), computed from all 32 bits of B.
    - ROL, ROR: k = B[4:0] (B mod 32).
  - Clear err.
  - If k=0 or op is illegal, go to DONE. Otherwise go to SHIFT.
- SHIFT, each cycle:
  - s = min(STEP, count); data←data shifted by s; count←count−s.
  - SHL and SHR zero-fill. SHRA fills with data[31]. ROL and ROR wrap around.
  - Go to DONE on the edge where count reaches 0.
- Entering DONE:
  - result←data.
  - For an illegal op: result←A (unchanged) and err←1.
- Shift amounts of 32 or more produce 0 for SHL/SHR, and 0x0000_0000 or 0xFFFF_FFFF (by sign) for SHRA. This matches single-cycle shifter semantics.
- start while in SHIFT is ignored. It is not queued.
- start during DONE is accepted. done still pulses that cycle, and back-to-back operation incurs no idle gap.
- Asynchronous reset at any time:
  - State goes to IDLE.
  - busy, done, err, result, count and data all go to 0.
  - An in-flight operation is discarded with no done.

## Timing
- Reset values: busy=0, done=0, err=0, result=0x0000_0000.
- Latency:
  - Let n = ceil(k/STEP).
  - done is high in cycle n+1 when counted from the accepting edge (cycle 1 is the cycle after that edge).
  - k=0 and illegal op: done in cycle 1.
- busy is high for exactly n cycles, immediately preceding done.
- result changes only on the edge entering DONE. It is stable when done is observed.
- done and busy are never high together.
- Throughput: one operation per n+1 cycles.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined: ROL and ROR are implemented as described.
- SHIFT_SEQ_ROTATE_EN undefined:
  - Opcodes 011 and 100 are treated as illegal (done in cycle 1, result=A, err=1).
  - The rotate datapath is removed.

## Test plan
- STEP=1, SHL, A=0x0000_0001, B=4 → busy for cycles 1–4, done in cycle 5, result=0x0000_0010, err=0.
- STEP=1, SHRA, A=0x8000_0000, B=40 → count clamps to 32, done in cycle 33, result=0xFFFF_FFFF. Repeat with SHR → result=0x0000_0000.
- STEP=4, ROR, A=0x0000_00F1, B=36:
  - With the macro: done in cycle 2, result=0x1000_000F.
  - Without the macro: done in cycle 1, result=0x0000_00F1, err=1.
- SHR, A=0x0000_1234, B=0 → no busy, done in cycle 1, result=0x0000_1234. op=111 gives the same timing with err=1.
- STEP=1, SHL B=3 in flight, start pulsed in cycle 2 → ignored. A new start held during the DONE cycle is accepted: busy is high in the next cycle and the second result is correct.
- reset_n low during cycle 2 of a STEP=1, B=10 shift → busy, done, err and result go to 0 immediately. After release, no done appears until a new start.
